// File: rtl/udp_status_replier.sv
// -----------------------------------------------------------------------------
// udp_status_replier
//
// Transmit-side companion to the panel UDP writer. A single-cycle reply request
// carrying the requester's IP/port starts one fixed-format status datagram on
// the liteeth udp_sink stream:
//   w0 MAGIC, w1 reply sequence number, w2 frame counter snapshot,
//   w3 status_word snapshot, w4 {16'b0, drop_count snapshot}
//   (+ w5 = XOR of w0..w4 when UDP_REPLY_CHECKSUM_EN is defined).
// Requests arriving while a reply is in flight are dropped and counted
// (saturating at 16'hFFFF).
//
// Optional feature macro: UDP_REPLY_CHECKSUM_EN (adds the XOR checksum word).
//
// Ports:
//   clock, resetn            system clock, synchronous active-low reset
//   req_valid/req_ip/req_port reply request and destination address
//   frame_done               one pulse per completed frame write
//   status_word              status snapshotted at request acceptance
//   busy                     reply in flight
//   drop_count               saturating count of rejected requests
//   udp_sink_*               liteeth UDP transmit stream (all registered)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module udp_status_replier #(
    parameter logic [15:0] LOCAL_PORT = 16'd6000,
    parameter logic [31:0] MAGIC      = 32'h4C454443
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [31:0] req_ip,
    input  logic [15:0] req_port,
    input  logic        frame_done,
    input  logic [31:0] status_word,
    output logic        busy,
    output logic [15:0] drop_count,
    output logic        udp_sink_valid,
    output logic        udp_sink_last,
    input  logic        udp_sink_ready,
    output logic [15:0] udp_sink_src_port,
    output logic [15:0] udp_sink_dst_port,
    output logic [31:0] udp_sink_ip_address,
    output logic [15:0] udp_sink_length,
    output logic [31:0] udp_sink_data,
    output logic [3:0]  udp_sink_error
);

`ifdef UDP_REPLY_CHECKSUM_EN
    localparam logic [2:0]  LAST_IDX = 3'd5;
    localparam logic [15:0] PKT_LEN  = 16'd24;
`else
    localparam logic [2:0]  LAST_IDX = 3'd4;
    localparam logic [15:0] PKT_LEN  = 16'd20;
`endif

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t      state_r, state_s;
    logic [2:0]  idx_r, idx_s;
    logic [31:0] seq_r, seq_s;
    logic [31:0] frame_cnt_r, frame_cnt_s;
    logic [15:0] drop_r, drop_s;
    logic [31:0] lat_frame_r, lat_frame_s;
    logic [31:0] lat_status_r, lat_status_s;
    logic [15:0] lat_drop_r, lat_drop_s;
    logic [31:0] ip_r, ip_s;
    logic [15:0] port_r, port_s;
    logic [15:0] len_r, len_s;
    logic [31:0] data_r, data_s;
    logic        valid_r, valid_s;
    logic        last_r, last_s;
    logic        busy_r, busy_s;
    logic [15:0] src_port_r;

    // Saturating increment for the rejected-request counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    // XOR check word over the five fixed payload words.
    function automatic logic [31:0] payload_xor(
        input logic [31:0] seq,
        input logic [31:0] frame,
        input logic [31:0] status,
        input logic [15:0] drop
    );
        return MAGIC ^ seq ^ frame ^ status ^ {16'h0000, drop};
    endfunction

    // Payload word selected by index, built from the values latched at acceptance.
    function automatic logic [31:0] payload_word(
        input logic [2:0]  idx,
        input logic [31:0] seq,
        input logic [31:0] frame,
        input logic [31:0] status,
        input logic [15:0] drop
    );
        logic [31:0] w;
        case (idx)
            3'd0:    w = MAGIC;
            3'd1:    w = seq;
            3'd2:    w = frame;
            3'd3:    w = status;
            3'd4:    w = {16'h0000, drop};
`ifdef UDP_REPLY_CHECKSUM_EN
            3'd5:    w = payload_xor(seq, frame, status, drop);
`endif
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and next-output logic; every output is registered from these.
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        seq_s        = seq_r;
        frame_cnt_s  = frame_cnt_r + {31'h0000_0000, frame_done};
        drop_s       = drop_r;
        lat_frame_s  = lat_frame_r;
        lat_status_s = lat_status_r;
        lat_drop_s   = lat_drop_r;
        ip_s         = ip_r;
        port_s       = port_r;
        len_s        = len_r;
        data_s       = data_r;
        valid_s      = valid_r;
        last_s       = last_r;
        busy_s       = busy_r;

        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    // frame_cnt_r is the pre-increment value even if frame_done
                    // coincides with acceptance.
                    lat_frame_s  = frame_cnt_r;
                    lat_status_s = status_word;
                    lat_drop_s   = drop_r;
                    ip_s         = req_ip;
                    port_s       = req_port;
                    len_s        = PKT_LEN;
                    idx_s        = 3'd0;
                    data_s       = MAGIC;
                    valid_s      = 1'b1;
                    last_s       = 1'b0;
                    busy_s       = 1'b1;
                    state_s      = ST_SEND;
                end else begin
                    valid_s = 1'b0;
                    last_s  = 1'b0;
                    busy_s  = 1'b0;
                end
            end
            ST_SEND: begin
                // Any request during SEND, including the final-handshake cycle,
                // is rejected.
                if (req_valid) begin
                    drop_s = sat_inc16(drop_r);
                end else begin
                    drop_s = drop_r;
                end
                if (valid_r && udp_sink_ready) begin
                    if (idx_r == LAST_IDX) begin
                        seq_s   = seq_r + 32'd1;
                        valid_s = 1'b0;
                        last_s  = 1'b0;
                        busy_s  = 1'b0;
                        state_s = ST_IDLE;
                    end else begin
                        idx_s  = idx_r + 3'd1;
                        data_s = payload_word(idx_r + 3'd1, seq_r, lat_frame_r,
                                              lat_status_r, lat_drop_r);
                        last_s = ((idx_r + 3'd1) == LAST_IDX);
                    end
                end else begin
                    // Stall: hold every stream field.
                    idx_s  = idx_r;
                    data_s = data_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                valid_s = 1'b0;
                last_s  = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            idx_r        <= 3'd0;
            seq_r        <= 32'h0000_0000;
            frame_cnt_r  <= 32'h0000_0000;
            drop_r       <= 16'h0000;
            lat_frame_r  <= 32'h0000_0000;
            lat_status_r <= 32'h0000_0000;
            lat_drop_r   <= 16'h0000;
            ip_r         <= 32'h0000_0000;
            port_r       <= 16'h0000;
            len_r        <= 16'h0000;
            data_r       <= 32'h0000_0000;
            valid_r      <= 1'b0;
            last_r       <= 1'b0;
            busy_r       <= 1'b0;
            src_port_r   <= LOCAL_PORT;
        end else begin
            idx_r        <= idx_s;
            seq_r        <= seq_s;
            frame_cnt_r  <= frame_cnt_s;
            drop_r       <= drop_s;
            lat_frame_r  <= lat_frame_s;
            lat_status_r <= lat_status_s;
            lat_drop_r   <= lat_drop_s;
            ip_r         <= ip_s;
            port_r       <= port_s;
            len_r        <= len_s;
            data_r       <= data_s;
            valid_r      <= valid_s;
            last_r       <= last_s;
            busy_r       <= busy_s;
            src_port_r   <= LOCAL_PORT;
        end
    end

    assign busy                = busy_r;
    assign drop_count          = drop_r;
    assign udp_sink_valid      = valid_r;
    assign udp_sink_last       = last_r;
    assign udp_sink_src_port   = src_port_r;
    assign udp_sink_dst_port   = port_r;
    assign udp_sink_ip_address = ip_r;
    assign udp_sink_length     = len_r;
    assign udp_sink_data       = data_r;
    assign udp_sink_error      = 4'b0000;

endmodule

// File: tb/tb_udp_status_replier.sv
`timescale 1ns/1ps

module tb_udp_status_replier;

`ifdef UDP_REPLY_CHECKSUM_EN
    localparam int NW = 6;
    localparam logic [15:0] EXP_LEN = 16'd24;
`else
    localparam int NW = 5;
    localparam logic [15:0] EXP_LEN = 16'd20;
`endif
    localparam logic [31:0] MAGIC_W = 32'h4C454443;

    logic        clock = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic [31:0] req_ip;
    logic [15:0] req_port;
    logic        frame_done;
    logic [31:0] status_word;
    logic        busy;
    logic [15:0] drop_count;
    logic        udp_sink_valid;
    logic        udp_sink_last;
    logic        udp_sink_ready;
    logic [15:0] udp_sink_src_port;
    logic [15:0] udp_sink_dst_port;
    logic [31:0] udp_sink_ip_address;
    logic [15:0] udp_sink_length;
    logic [31:0] udp_sink_data;
    logic [3:0]  udp_sink_error;

    int total = 0;
    int bad   = 0;
    logic [31:0] rx_words [0:5];
    int rx_n;

    udp_status_replier dut (
        .clock               (clock),
        .resetn              (resetn),
        .req_valid           (req_valid),
        .req_ip              (req_ip),
        .req_port            (req_port),
        .frame_done          (frame_done),
        .status_word         (status_word),
        .busy                (busy),
        .drop_count          (drop_count),
        .udp_sink_valid      (udp_sink_valid),
        .udp_sink_last       (udp_sink_last),
        .udp_sink_ready      (udp_sink_ready),
        .udp_sink_src_port   (udp_sink_src_port),
        .udp_sink_dst_port   (udp_sink_dst_port),
        .udp_sink_ip_address (udp_sink_ip_address),
        .udp_sink_length     (udp_sink_length),
        .udp_sink_data       (udp_sink_data),
        .udp_sink_error      (udp_sink_error)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request and check the first word appears on the next edge.
    task automatic request(input logic [31:0] ip, input logic [15:0] port,
                           input logic [31:0] status, input logic fd);
        req_valid   = 1'b1;
        req_ip      = ip;
        req_port    = port;
        status_word = status;
        frame_done  = fd;
        tick();
        req_valid  = 1'b0;
        frame_done = 1'b0;
        check32("acc_valid", {31'h0, udp_sink_valid}, 32'd1);
        check32("acc_busy",  {31'h0, busy}, 32'd1);
        check32("acc_w0",    udp_sink_data, MAGIC_W);
        check32("acc_ip",    udp_sink_ip_address, ip);
        check32("acc_port",  {16'h0, udp_sink_dst_port}, {16'h0, port});
        check32("acc_len",   {16'h0, udp_sink_length}, {16'h0, EXP_LEN});
    endtask

    // Collect one packet; optionally toggle ready and inject requests.
    task automatic recv_packet(input bit toggle, input int req_at_hs, input bit req_on_last);
        bit          done;
        bit          stalled;
        logic [31:0] prev;
        done    = 1'b0;
        stalled = 1'b0;
        prev    = 32'h0;
        rx_n    = 0;
        for (int c = 0; c < 64 && !done; c++) begin
            if (stalled) check32("stall_data", udp_sink_data, prev);
            stalled = 1'b0;
            if (udp_sink_valid && udp_sink_ready) begin
                rx_words[rx_n] = udp_sink_data;
                check32("last_flag", {31'h0, udp_sink_last}, (rx_n == NW-1) ? 32'd1 : 32'd0);
                if (rx_n == NW-1) begin
                    done = 1'b1;
                    if (req_on_last) req_valid = 1'b1;
                end else if (rx_n == req_at_hs) begin
                    req_valid = 1'b1;
                end
                rx_n++;
            end else if (udp_sink_valid) begin
                prev    = udp_sink_data;
                stalled = 1'b1;
            end
            tick();
            req_valid = 1'b0;
            if (toggle) udp_sink_ready = ~udp_sink_ready;
        end
        check32("pkt_done",  {31'h0, done}, 32'd1);
        check32("hs_count",  rx_n, NW);
        check32("post_valid", {31'h0, udp_sink_valid}, 32'd0);
        check32("post_last",  {31'h0, udp_sink_last}, 32'd0);
        check32("post_busy",  {31'h0, busy}, 32'd0);
    endtask

    task automatic check_words(input logic [31:0] seq, input logic [31:0] frame,
                               input logic [31:0] status, input logic [15:0] drop);
        logic [31:0] exp [0:5];
        exp[0] = MAGIC_W;
        exp[1] = seq;
        exp[2] = frame;
        exp[3] = status;
        exp[4] = {16'h0, drop};
        exp[5] = MAGIC_W ^ seq ^ frame ^ status ^ {16'h0, drop};
        for (int i = 0; i < NW; i++) begin
            check32($sformatf("word%0d", i), rx_words[i], exp[i]);
        end
    endtask

    initial begin
        resetn         = 1'b0;
        req_valid      = 1'b0;
        req_ip         = 32'h0;
        req_port       = 16'h0;
        frame_done     = 1'b0;
        status_word    = 32'h0;
        udp_sink_ready = 1'b1;
        tick();
        tick();
        // Reset state
        check32("rst_valid", {31'h0, udp_sink_valid}, 32'd0);
        check32("rst_last",  {31'h0, udp_sink_last}, 32'd0);
        check32("rst_busy",  {31'h0, busy}, 32'd0);
        check32("rst_data",  udp_sink_data, 32'h0);
        check32("rst_src",   {16'h0, udp_sink_src_port}, 32'd6000);
        check32("rst_len",   {16'h0, udp_sink_length}, 32'd0);
        check32("rst_drop",  {16'h0, drop_count}, 32'd0);
        check32("rst_err",   {28'h0, udp_sink_error}, 32'd0);
        resetn = 1'b1;
        tick();

        // Packet 1: basic, ready held high
        request(32'hC0A80132, 16'h1234, 32'hDEADBEEF, 1'b0);
        recv_packet(1'b0, -1, 1'b0);
        check_words(32'd0, 32'd0, 32'hDEADBEEF, 16'd0);

        // Packet 2: three frames, ready toggling
        for (int i = 0; i < 3; i++) begin
            frame_done = 1'b1;
            tick();
            frame_done = 1'b0;
            tick();
        end
        request(32'h0A000001, 16'hBEEF, 32'h12345678, 1'b0);
        recv_packet(1'b1, -1, 1'b0);
        check_words(32'd1, 32'd3, 32'h12345678, 16'd0);
        udp_sink_ready = 1'b1;

        // Packet 3: requests mid-packet and on the last handshake are dropped
        request(32'h0A000002, 16'h0101, 32'hCAFEF00D, 1'b0);
        recv_packet(1'b0, 1, 1'b1);
        check_words(32'd2, 32'd3, 32'hCAFEF00D, 16'd0);
        check32("drop_two", {16'h0, drop_count}, 32'd2);
        check32("dst_kept", {16'h0, udp_sink_dst_port}, 32'h0101);

        // Packet 4: frame_done coincident with acceptance snapshots old value
        request(32'h0A000003, 16'h0202, 32'h0F0F0F0F, 1'b1);
        recv_packet(1'b0, -1, 1'b0);
        check_words(32'd3, 32'd3, 32'h0F0F0F0F, 16'd2);

        // Packet 5: reset after w2 handshake
        request(32'h0A000004, 16'h0303, 32'h55AA55AA, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check32("mid_last", {31'h0, udp_sink_last}, 32'd0);
        end
        check32("mid_w3", udp_sink_data, 32'h55AA55AA);
        resetn = 1'b0;
        tick();
        check32("abort_valid", {31'h0, udp_sink_valid}, 32'd0);
        check32("abort_last",  {31'h0, udp_sink_last}, 32'd0);
        check32("abort_busy",  {31'h0, busy}, 32'd0);
        check32("abort_drop",  {16'h0, drop_count}, 32'd0);
        check32("abort_ip",    udp_sink_ip_address, 32'h0);
        check32("abort_src",   {16'h0, udp_sink_src_port}, 32'd6000);
        resetn = 1'b1;
        tick();

        // Packet 6: counters restart from zero
        request(32'hC0A80001, 16'h4321, 32'hA5A5A5A5, 1'b0);
        recv_packet(1'b0, -1, 1'b0);
        check_words(32'd0, 32'd0, 32'hA5A5A5A5, 16'd0);

        // Packet 7: drop counter saturation while stalled
        udp_sink_ready = 1'b0;
        request(32'hC0A80002, 16'h0007, 32'h00000077, 1'b0);
        req_valid = 1'b1;
        for (int i = 0; i < 65535; i++) tick();
        check32("sat_reach", {16'h0, drop_count}, 32'h0000FFFF);
        for (int i = 0; i < 5; i++) tick();
        req_valid = 1'b0;
        check32("sat_hold",  {16'h0, drop_count}, 32'h0000FFFF);
        check32("sat_valid", {31'h0, udp_sink_valid}, 32'd1);
        check32("sat_data",  udp_sink_data, MAGIC_W);
        udp_sink_ready = 1'b1;
        recv_packet(1'b0, -1, 1'b0);
        check_words(32'd1, 32'd0, 32'h00000077, 16'd0);
        check32("sat_after", {16'h0, drop_count}, 32'h0000FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
